pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Reset sequencer placed directly downstream of the 204 MHz PLL wrapper. It runs on the PLL output clock and synchronises and debounces the PLL `locked` flag. It releases a clean, synchronously-deasserted system reset only after lock has been stable for a programmable time plus a hold-off. It re-asserts system reset on any loss of lock and records lock-loss events for debug.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for `locked`; legal range 2..4.
- `LOCK_CYCLES`, default 1024: consecutive cycles `locked_s` must stay high; minimum 1.
- `HOLD_CYCLES`, default 16: extra cycles that reset is held after lock qualifies; minimum 1.

Ports:
- `clock`  in  1: PLL output clock (the PLL wrapper's `clock_out`); all logic is on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `locked`  in  1: PLL lock flag; asynchronous to `clock` and may glitch.
- `clear_lost`  in  1: synchronous, single-cycle clear of `lock_lost`.
- `sys_reset_n`  out  1: registered, active-low system reset for downstream logic.
- `lock_lost`  out  1: sticky flag; set on every RUN-to-loss transition.
- `lock_loss_count`  out  8: saturating count of lock losses seen in RUN.
- `state`  out  2: FSM state. 0 = WAIT_LOCK, 1 = HOLD, 2 = RUN; 3 is never driven.

## Operation

- **Synchroniser.** `locked` passes through `SYNC_STAGES` flops. Call the last flop's output `locked_s`.
- **Counter.** One shared counter, `$clog2(max(LOCK_CYCLES, HOLD_CYCLES))+1` bits wide. It is cleared on every state change.
- **WAIT_LOCK.**
  - Each edge with `locked_s`=1 increments the counter.
  - Any edge with `locked_s`=0 clears the counter and stays in WAIT_LOCK, so a single-cycle glitch restarts qualification.
  - On the LOCK_CYCLES-th consecutive high edge, go to HOLD.
- **HOLD.**
  - The counter increments each edge.
  - If `locked_s`=0, go to WAIT_LOCK.
  - On the HOLD_CYCLES-th edge, go to RUN.
- **RUN.**
  - If `locked_s`=0, go to WAIT_LOCK.
  - On that same edge: set `lock_lost`, and increment `lock_loss_count` unless it is at 255, where it holds.
- **Reset output.** `sys_reset_n` is 1 only while the registered state is RUN. It is registered alongside the state, never decoded combinationally.
- **Lock-lost flag.**
  - `clear_lost`=1 clears `lock_lost` on the next edge.
  - If a loss event occurs on the same edge as a clear, the loss wins: `lock_lost` stays 1.
  - `clear_lost` has no effect on `lock_loss_count`.
- **Reset (asynchronous, `resetn`=0).**
  - `sys_reset_n`=0, `state`=0 (WAIT_LOCK), counter=0.
  - All synchroniser flops=0, `lock_lost`=0, `lock_loss_count`=0.
  - This takes effect immediately, with no clock needed, including mid-HOLD or mid-RUN.
- **Reset release.** After `resetn` rises, the full qualification sequence always runs again; there is no shortcut.

## Timing

- Let edge 1 be the first rising edge that samples `locked`=1, with `locked` held high from then on.
  - `sys_reset_n` reads 1 after exactly L = SYNC_STAGES + LOCK_CYCLES + HOLD_CYCLES edges.
  - With default parameters, L = 1042 cycles, about 5.1 µs at 204 MHz.
- Let edge 1 be the first edge that samples `locked`=0 while in RUN.
  - `sys_reset_n` reads 0, and `lock_lost`/`lock_loss_count` update, after exactly SYNC_STAGES+1 edges.
- A `locked` low pulse that is captured by at least one edge propagates to the FSM.
  - In WAIT_LOCK it restarts the count.
  - In HOLD or RUN it forces WAIT_LOCK.
- `sys_reset_n` never glitches high: there is no combinational path from `locked` or `resetn` to it.
- `resetn` assertion forces all outputs low asynchronously.
- `resetn` deassertion must meet recovery timing for `clock`; the integrator guarantees this.

## Test plan

Unless stated, use SYNC_STAGES=2, LOCK_CYCLES=8, HOLD_CYCLES=4.

1. **Nominal lock.** Release `resetn`, then raise `locked` and hold it.
   - `state` goes 0→1→2.
   - `sys_reset_n` rises exactly 14 edges after the first high sample.
   - `lock_loss_count` stays 0.
2. **Glitch during qualification.** `locked` high for 6 sampled cycles, low for 1, then high.
   - `sys_reset_n` rises 14 edges after the re-rise sample.
   - No loss is counted.
3. **Loss in RUN.** Reach RUN, then drop `locked` for 1 cycle.
   - `sys_reset_n`=0 exactly 3 edges after the low sample.
   - `lock_lost`=1 and `lock_loss_count`=1.
   - The block requalifies and returns to RUN.
4. **Saturation and clear priority.**
   - Cause 257 RUN losses: count reads 255 throughout the last two.
   - Pulse `clear_lost` on the same edge as a loss: `lock_lost` stays 1.
   - Pulse `clear_lost` alone: `lock_lost` reads 0 on the next edge.
5. **Reset mid-operation.**
   - Assert `resetn` mid-HOLD, then again in RUN, between clock edges.
   - All outputs read 0 immediately.
   - After release with `locked` high, `sys_reset_n` rises after 14 edges.
6. **Default parameters.** Nominal lock gives `sys_reset_n` rising after exactly 1042 edges.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// Reset sequencer for the PLL output clock domain: synchronises and qualifies the
// PLL lock flag, releases a synchronously-deasserted system reset and logs lock losses.
module pll_reset_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       locked,
    input  logic       clear_lost,
    output logic       sys_reset_n,
    output logic       lock_lost,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    // Terminal counts are one less than the cycle counts because the transition
    // happens on the edge that would otherwise complete the final increment.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic                   w_loss_event;
    logic                   w_loss_sat;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sys_reset_n;
    logic                   r_lock_lost;
    logic [7:0]             r_loss_cnt;

    // Lock flag synchroniser chain; the last stage feeds the FSM.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s   = r_sync[SYNC_STAGES-1];
    assign w_loss_event = (r_state == ST_RUN) && !w_locked_s;
    assign w_loss_sat   = (r_loss_cnt == 8'hFF);

    // Qualification FSM with the system reset registered alongside the state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_WAIT_LOCK;
            r_cnt         <= '0;
            r_sys_reset_n <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    r_sys_reset_n <= 1'b0;
                    if (!w_locked_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!w_locked_s) begin
                        r_state       <= ST_WAIT_LOCK;
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state       <= ST_RUN;
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b1;
                    end else begin
                        r_cnt         <= r_cnt + CNT_ONE;
                        r_sys_reset_n <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state       <= ST_WAIT_LOCK;
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b0;
                    end else begin
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_WAIT_LOCK;
                    r_cnt         <= '0;
                    r_sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

    // Lock-loss bookkeeping: a loss on the same edge as a clear keeps the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lock_lost <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            if (w_loss_event) begin
                r_lock_lost <= 1'b1;
            end else if (clear_lost) begin
                r_lock_lost <= 1'b0;
            end else begin
                r_lock_lost <= r_lock_lost;
            end

            if (w_loss_event && !w_loss_sat) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end else begin
                r_loss_cnt <= r_loss_cnt;
            end
        end
    end

    assign sys_reset_n     = r_sys_reset_n;
    assign lock_lost       = r_lock_lost;
    assign lock_loss_count = r_loss_cnt;
    assign state           = r_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: a small-parameter instance for sequencing,
// loss and reset behaviour, plus a default-parameter instance for the full latency.
module tb_pll_reset_ctrl;

    logic       clock;
    logic       resetn;
    logic       locked;
    logic       clear_lost;
    logic       sys_reset_n;
    logic       lock_lost;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    logic       resetn_d;
    logic       locked_d;
    logic       clear_lost_d;
    logic       sys_reset_n_d;
    logic       lock_lost_d;
    logic [7:0] lock_loss_count_d;
    logic [1:0] state_d;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_ctrl #(
        .SYNC_STAGES(2),
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .locked         (locked),
        .clear_lost     (clear_lost),
        .sys_reset_n    (sys_reset_n),
        .lock_lost      (lock_lost),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    pll_reset_ctrl dut_d (
        .clock          (clock),
        .resetn         (resetn_d),
        .locked         (locked_d),
        .clear_lost     (clear_lost_d),
        .sys_reset_n    (sys_reset_n_d),
        .lock_lost      (lock_lost_d),
        .lock_loss_count(lock_loss_count_d),
        .state          (state_d)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge for sampling/driving.
    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_sysrst"}, 32'(sys_reset_n), 32'd0);
        check_val({tag, "_state"},  32'(state),       32'd0);
        check_val({tag, "_lost"},   32'(lock_lost),   32'd0);
        check_val({tag, "_count"},  32'(lock_loss_count), 32'd0);
    endtask

    initial begin
        clear_lost   = 1'b0;
        locked       = 1'b0;
        resetn       = 1'b1;
        resetn_d     = 1'b1;
        locked_d     = 1'b0;
        clear_lost_d = 1'b0;
        #2;
        resetn   = 1'b0;
        resetn_d = 1'b0;
        #1;
        check_all_zero("reset");

        // 1: nominal lock, 2 + 8 + 4 = 14 edges
        edges(2);
        resetn = 1'b1;
        locked = 1'b1;
        edges(9);
        check_val("t1_state_e9", 32'(state), 32'd0);
        edges(1);
        check_val("t1_state_e10", 32'(state), 32'd1);
        edges(3);
        check_val("t1_sysrst_e13", 32'(sys_reset_n), 32'd0);
        edges(1);
        check_val("t1_sysrst_e14", 32'(sys_reset_n), 32'd1);
        check_val("t1_state_e14", 32'(state), 32'd2);
        check_val("t1_count", 32'(lock_loss_count), 32'd0);

        // 2: glitch during qualification restarts the count
        resetn = 1'b0;
        locked = 1'b0;
        #1;
        check_all_zero("t2_rst");
        edges(2);
        resetn = 1'b1;
        locked = 1'b1;
        edges(6);
        locked = 1'b0;
        edges(1);
        locked = 1'b1;
        edges(13);
        check_val("t2_sysrst_e13", 32'(sys_reset_n), 32'd0);
        check_val("t2_state_e13", 32'(state), 32'd1);
        edges(1);
        check_val("t2_sysrst_e14", 32'(sys_reset_n), 32'd1);
        check_val("t2_count", 32'(lock_loss_count), 32'd0);
        check_val("t2_lost", 32'(lock_lost), 32'd0);

        // 3: single-cycle loss in RUN
        locked = 1'b0;
        edges(1);
        locked = 1'b1;
        edges(1);
        check_val("t3_sysrst_e2", 32'(sys_reset_n), 32'd1);
        edges(1);
        check_val("t3_sysrst_e3", 32'(sys_reset_n), 32'd0);
        check_val("t3_lost", 32'(lock_lost), 32'd1);
        check_val("t3_count", 32'(lock_loss_count), 32'd1);
        check_val("t3_state", 32'(state), 32'd0);
        edges(12);
        check_val("t3_requal_sysrst", 32'(sys_reset_n), 32'd1);
        check_val("t3_requal_state", 32'(state), 32'd2);

        // 4: saturation of the loss counter
        for (int k = 2; k <= 257; k++) begin
            locked = 1'b0;
            edges(1);
            locked = 1'b1;
            edges(2);
            check_val("t4_count_loss", 32'(lock_loss_count), (k > 255) ? 32'd255 : 32'(k));
            edges(12);
            if (k >= 256) begin
                check_val("t4_count_run", 32'(lock_loss_count), 32'd255);
                check_val("t4_state_run", 32'(state), 32'd2);
            end
        end

        // 4: clear alone, then clear colliding with a loss
        clear_lost = 1'b1;
        edges(1);
        clear_lost = 1'b0;
        check_val("t4_clear_alone", 32'(lock_lost), 32'd0);
        check_val("t4_clear_count", 32'(lock_loss_count), 32'd255);
        edges(2);
        check_val("t4_clear_stays", 32'(lock_lost), 32'd0);
        locked = 1'b0;
        edges(1);
        locked = 1'b1;
        edges(1);
        clear_lost = 1'b1;
        edges(1);
        clear_lost = 1'b0;
        check_val("t4_clear_vs_loss", 32'(lock_lost), 32'd1);
        check_val("t4_cv_sysrst", 32'(sys_reset_n), 32'd0);
        check_val("t4_cv_count", 32'(lock_loss_count), 32'd255);
        edges(1);
        check_val("t4_lost_sticky", 32'(lock_lost), 32'd1);
        edges(11);
        check_val("t4_requal_state", 32'(state), 32'd2);

        // 5: asynchronous reset mid-HOLD, then mid-RUN
        locked = 1'b0;
        edges(1);
        locked = 1'b1;
        edges(2);
        edges(9);
        check_val("t5_in_hold", 32'(state), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("t5_hold_rst");
        edges(1);
        resetn = 1'b1;
        edges(13);
        check_val("t5_h_sysrst_e13", 32'(sys_reset_n), 32'd0);
        edges(1);
        check_val("t5_h_sysrst_e14", 32'(sys_reset_n), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("t5_run_rst");
        edges(1);
        resetn = 1'b1;
        edges(13);
        check_val("t5_r_sysrst_e13", 32'(sys_reset_n), 32'd0);
        edges(1);
        check_val("t5_r_sysrst_e14", 32'(sys_reset_n), 32'd1);

        // 6: default parameters, 2 + 1024 + 16 = 1042 edges
        check_val("t6_reset_sysrst", 32'(sys_reset_n_d), 32'd0);
        resetn_d = 1'b1;
        locked_d = 1'b1;
        edges(1041);
        check_val("t6_sysrst_e1041", 32'(sys_reset_n_d), 32'd0);
        check_val("t6_state_e1041", 32'(state_d), 32'd1);
        edges(1);
        check_val("t6_sysrst_e1042", 32'(sys_reset_n_d), 32'd1);
        check_val("t6_state_e1042", 32'(state_d), 32'd2);
        check_val("t6_count", 32'(lock_loss_count_d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
